// File: rtl/decode_if.sv
// Fetch-to-decode and decode-to-execute signal bundle for the RV64IM decoder.
interface decode_if;
  logic [31:0] instr_reg;
  logic [63:0] IFID_npc;
  logic        IFID_ready;
  logic        IDEX_ready;
  logic [63:0] IDEX_npc;
  logic [63:0] opcode;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic [5:0]  rd;
  logic [19:0] immediate;

  modport master (
    output instr_reg, IFID_npc, IFID_ready,
    input  IDEX_ready, IDEX_npc, opcode, rs1, rs2, rd, immediate
  );

  modport slave (
    input  instr_reg, IFID_npc, IFID_ready,
    output IDEX_ready, IDEX_npc, opcode, rs1, rs2, rd, immediate
  );
endinterface

// File: rtl/decode_mod.sv
// RV64IM single-cycle instruction decoder: registers an operation code,
// register indices and a 20-bit immediate for every accepted instruction.
module decode_mod (
  input  logic     clk,
  input  logic     reset,
  decode_if.slave  bus
);
  localparam int unsigned OP_W  = 7;
  localparam int unsigned IMM_W = 20;

  localparam logic [2:0] FMT_N   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_SH6 = 3'd6;
  localparam logic [2:0] FMT_SH5 = 3'd7;

  logic [31:0]      ins;
  logic [6:0]       opc;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [5:0]       f6;
  logic [OP_W-1:0]  dec_op;
  logic [2:0]       dec_fmt;
  logic [IMM_W-1:0] dec_imm;

  logic             ready_q, ready_d;
  logic [63:0]      npc_q, npc_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [IMM_W-1:0] imm_q, imm_d;

  assign ins = bus.instr_reg;
  assign opc = ins[6:0];
  assign f3  = ins[14:12];
  assign f7  = ins[31:25];
  assign f6  = ins[31:26];

  // Operation code and immediate format; anything unmatched stays ILLEGAL/FMT_N.
  always_comb begin
    dec_op  = '0;
    dec_fmt = FMT_N;
    case (opc)
      7'b0110111: begin dec_op = 7'd1; dec_fmt = FMT_U; end
      7'b0010111: begin dec_op = 7'd2; dec_fmt = FMT_U; end
      7'b1101111: begin dec_op = 7'd3; dec_fmt = FMT_J; end
      7'b1100111: if (f3 == 3'd0) begin dec_op = 7'd4; dec_fmt = FMT_I; end
      7'b1100011: begin
        dec_fmt = FMT_B;
        case (f3)
          3'd0: dec_op = 7'd5;
          3'd1: dec_op = 7'd6;
          3'd4: dec_op = 7'd7;
          3'd5: dec_op = 7'd8;
          3'd6: dec_op = 7'd9;
          3'd7: dec_op = 7'd10;
          default: dec_op = '0;
        endcase
      end
      7'b0000011: if (f3 != 3'd7) begin dec_op = 7'd11 + {4'd0, f3}; dec_fmt = FMT_I; end
      7'b0100011: if (!f3[2]) begin dec_op = 7'd18 + {4'd0, f3}; dec_fmt = FMT_S; end
      7'b0010011: begin
        dec_fmt = FMT_I;
        case (f3)
          3'd0: dec_op = 7'd22;
          3'd2: dec_op = 7'd23;
          3'd3: dec_op = 7'd24;
          3'd4: dec_op = 7'd25;
          3'd6: dec_op = 7'd26;
          3'd7: dec_op = 7'd27;
          3'd1: if (f6 == 6'b000000) begin dec_op = 7'd28; dec_fmt = FMT_SH6; end
          default: begin
            if (f6 == 6'b000000) begin dec_op = 7'd29; dec_fmt = FMT_SH6; end
            else if (f6 == 6'b010000) begin dec_op = 7'd30; dec_fmt = FMT_SH6; end
          end
        endcase
      end
      7'b0110011: begin
        if (f7 == 7'b0000001) dec_op = 7'd50 + {4'd0, f3};
        else if (f7 == 7'b0000000) begin
          case (f3)
            3'd0: dec_op = 7'd31;
            3'd1: dec_op = 7'd33;
            3'd2: dec_op = 7'd34;
            3'd3: dec_op = 7'd35;
            3'd4: dec_op = 7'd36;
            3'd5: dec_op = 7'd37;
            3'd6: dec_op = 7'd39;
            default: dec_op = 7'd40;
          endcase
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'd0) dec_op = 7'd32;
          else if (f3 == 3'd5) dec_op = 7'd38;
        end
      end
      7'b0011011: begin
        if (f3 == 3'd0) begin dec_op = 7'd41; dec_fmt = FMT_I; end
        else if (f3 == 3'd1 && f7 == 7'b0000000) begin dec_op = 7'd42; dec_fmt = FMT_SH5; end
        else if (f3 == 3'd5 && f7 == 7'b0000000) begin dec_op = 7'd43; dec_fmt = FMT_SH5; end
        else if (f3 == 3'd5 && f7 == 7'b0100000) begin dec_op = 7'd44; dec_fmt = FMT_SH5; end
      end
      7'b0111011: begin
        if (f7 == 7'b0000000) begin
          if (f3 == 3'd0) dec_op = 7'd45;
          else if (f3 == 3'd1) dec_op = 7'd47;
          else if (f3 == 3'd5) dec_op = 7'd48;
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'd0) dec_op = 7'd46;
          else if (f3 == 3'd5) dec_op = 7'd49;
        end else if (f7 == 7'b0000001) begin
          case (f3)
            3'd0: dec_op = 7'd58;
            3'd4: dec_op = 7'd59;
            3'd5: dec_op = 7'd60;
            3'd6: dec_op = 7'd61;
            3'd7: dec_op = 7'd62;
            default: dec_op = '0;
          endcase
        end
      end
      7'b1110011: if (f3 == 3'd0 && ins[31:20] == 12'd0) dec_op = 7'd63;
      7'b0001111: if (f3 == 3'd0) dec_op = 7'd64;
      default: dec_op = '0;
    endcase
    if (dec_op == '0) dec_fmt = FMT_N;
  end

  // Immediate assembly from the selected format.
  always_comb begin
    dec_imm = '0;
    case (dec_fmt)
      FMT_I:   dec_imm = {{8{ins[31]}}, ins[31:20]};
      FMT_S:   dec_imm = {{8{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   dec_imm = {{7{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:   dec_imm = ins[31:12];
      FMT_J:   dec_imm = {ins[31], ins[19:12], ins[20], ins[30:21]};
      FMT_SH6: dec_imm = {14'd0, ins[25:20]};
      FMT_SH5: dec_imm = {15'd0, ins[24:20]};
      default: dec_imm = '0;
    endcase
  end

  // Capture on IFID_ready; otherwise hold the bundle and drop IDEX_ready.
  always_comb begin
    ready_d = 1'b0;
    npc_d   = npc_q;
    op_d    = op_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    imm_d   = imm_q;
    if (bus.IFID_ready) begin
      ready_d = 1'b1;
      npc_d   = bus.IFID_npc;
      op_d    = dec_op;
      rs1_d   = ins[19:15];
      rs2_d   = ins[24:20];
      rd_d    = ins[11:7];
      imm_d   = dec_imm;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q <= 1'b0;
      npc_q   <= '0;
      op_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
    end else begin
      ready_q <= ready_d;
      npc_q   <= npc_d;
      op_q    <= op_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
    end
  end

  assign bus.IDEX_ready = ready_q;
  assign bus.IDEX_npc   = npc_q;
  assign bus.opcode     = 64'(op_q);
  assign bus.rs1        = 64'(rs1_q);
  assign bus.rs2        = 64'(rs2_q);
  assign bus.rd         = {1'b0, rd_q};
  assign bus.immediate  = imm_q;
endmodule

// File: tb/tb_decode_mod.sv
// Directed and randomized checks of decode_mod against a mask/match table model.
module tb_decode_mod;
  logic clk = 1'b0;
  logic reset;
  decode_if bus ();

  decode_mod u_dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [63:0] e_npc, e_op, e_rs1, e_rs2;
  logic [5:0]  e_rd;
  logic [19:0] e_imm;
  logic        e_rdy;

  // Instruction table: first entry whose masked bits match wins.
  int unsigned pat_mask[$];
  int unsigned pat_match[$];
  int          pat_code[$];
  int          pat_fmt[$];   // 0 none,1 I,2 S,3 B,4 U,5 J,6 shamt6,7 shamt5

  function automatic void add_pat(int unsigned m, int unsigned v, int code, int fmt);
    pat_mask.push_back(m);
    pat_match.push_back(v);
    pat_code.push_back(code);
    pat_fmt.push_back(fmt);
  endfunction

  function automatic void build_table();
    int bf3[6] = '{0, 1, 4, 5, 6, 7};
    int if3[6] = '{0, 2, 3, 4, 6, 7};
    int rf7[10] = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
    int wf7[10] = '{0, 32, 0, 0, 32, 1, 1, 1, 1, 1};
    int wf3[10] = '{0, 0, 1, 5, 5, 0, 4, 5, 6, 7};
    add_pat(32'h7F, 32'h37, 1, 4);
    add_pat(32'h7F, 32'h17, 2, 4);
    add_pat(32'h7F, 32'h6F, 3, 5);
    add_pat(32'h707F, 32'h67, 4, 1);
    for (int i = 0; i < 6; i++) add_pat(32'h707F, 32'h63 | (bf3[i] << 12), 5 + i, 3);
    for (int i = 0; i < 7; i++) add_pat(32'h707F, 32'h03 | (i << 12), 11 + i, 1);
    for (int i = 0; i < 4; i++) add_pat(32'h707F, 32'h23 | (i << 12), 18 + i, 2);
    for (int i = 0; i < 6; i++) add_pat(32'h707F, 32'h13 | (if3[i] << 12), 22 + i, 1);
    add_pat(32'hFC00707F, 32'h00001013, 28, 6);
    add_pat(32'hFC00707F, 32'h00005013, 29, 6);
    add_pat(32'hFC00707F, 32'h40005013, 30, 6);
    // R-type base ops in code order: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND
    for (int i = 0; i < 10; i++) begin
      int f3v;
      f3v = (i == 0 || i == 1) ? 0 : (i == 7) ? 5 : i - 1;
      if (i >= 8) f3v = i - 2;
      add_pat(32'hFE00707F, 32'h33 | (f3v << 12) | (rf7[i] << 25), 31 + i, 0);
    end
    add_pat(32'h707F, 32'h1B, 41, 1);
    add_pat(32'hFE00707F, 32'h0000101B, 42, 7);
    add_pat(32'hFE00707F, 32'h0000501B, 43, 7);
    add_pat(32'hFE00707F, 32'h4000501B, 44, 7);
    for (int i = 0; i < 8; i++) add_pat(32'hFE00707F, 32'h02000033 | (i << 12), 50 + i, 0);
    for (int i = 0; i < 10; i++)
      add_pat(32'hFE00707F, 32'h3B | (wf3[i] << 12) | (wf7[i] << 25), (i < 5) ? 45 + i : 53 + i, 0);
    add_pat(32'hFFF0707F, 32'h73, 63, 0);
    add_pat(32'h707F, 32'h0F, 64, 0);
  endfunction

  function automatic void model(input logic [31:0] ins, output int code, output logic [19:0] imm);
    logic signed [31:0] v;
    int fmt;
    code = 0;
    fmt  = 0;
    for (int k = 0; k < pat_mask.size(); k++) begin
      if ((ins & pat_mask[k]) == pat_match[k]) begin
        code = pat_code[k];
        fmt  = pat_fmt[k];
        break;
      end
    end
    v   = 0;
    imm = '0;
    case (fmt)
      1: begin v = $signed(ins[31:20]); imm = v[19:0]; end
      2: begin v = $signed({ins[31:25], ins[11:7]}); imm = v[19:0]; end
      3: begin v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}); imm = v[19:0]; end
      4: imm = ins[31:12];
      5: begin
        v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
        v = v >>> 1;
        imm = v[19:0];
      end
      6: imm = 20'(ins[25:20]);
      7: imm = 20'(ins[24:20]);
      default: imm = '0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ready"}, 64'(bus.IDEX_ready), 64'(e_rdy));
    chk({tag, ".npc"}, bus.IDEX_npc, e_npc);
    chk({tag, ".opcode"}, bus.opcode, e_op);
    chk({tag, ".rs1"}, bus.rs1, e_rs1);
    chk({tag, ".rs2"}, bus.rs2, e_rs2);
    chk({tag, ".rd"}, 64'(bus.rd), 64'(e_rd));
    chk({tag, ".imm"}, 64'(bus.immediate), 64'(e_imm));
  endtask

  task automatic clear_exp();
    e_rdy = 1'b0; e_npc = '0; e_op = '0; e_rs1 = '0; e_rs2 = '0; e_rd = '0; e_imm = '0;
  endtask

  // Present one cycle of input, then check one step after the capturing edge.
  task automatic step(input string tag, input logic v, input logic [31:0] ins, input logic [63:0] npc);
    int code;
    logic [19:0] imm;
    @(negedge clk);
    bus.IFID_ready = v;
    bus.instr_reg  = ins;
    bus.IFID_npc   = npc;
    @(posedge clk);
    #1;
    e_rdy = v;
    if (v) begin
      model(ins, code, imm);
      e_npc = npc;
      e_op  = 64'(code);
      e_rs1 = 64'(ins[19:15]);
      e_rs2 = 64'(ins[24:20]);
      e_rd  = {1'b0, ins[11:7]};
      e_imm = imm;
    end
    check_all(tag);
  endtask

  initial begin
    logic [31:0] r;
    int k;
    build_table();
    bus.IFID_ready = 1'b0;
    bus.instr_reg  = '0;
    bus.IFID_npc   = '0;
    reset = 1'b0;
    clear_exp();
    #1;
    check_all("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    step("addi", 1'b1, 32'h00500093, 64'h1004);
    chk("addi.spec_op", bus.opcode, 64'd22);
    chk("addi.spec_imm", 64'(bus.immediate), 64'h00005);
    step("add", 1'b1, 32'h002081B3, 64'h1008);
    chk("add.spec_op", bus.opcode, 64'd31);
    step("addi_neg", 1'b1, 32'hFFF00093, 64'h100C);
    chk("addi_neg.spec_imm", 64'(bus.immediate), 64'hFFFFF);
    step("beq", 1'b1, 32'hFE000EE3, 64'h1010);
    chk("beq.spec_op", bus.opcode, 64'd5);
    chk("beq.spec_imm", 64'(bus.immediate), 64'hFFFFC);
    step("lui", 1'b1, 32'h123452B7, 64'h1014);
    chk("lui.spec_imm", 64'(bus.immediate), 64'h12345);
    step("allones", 1'b1, 32'hFFFFFFFF, 64'h1018);
    chk("allones.spec_op", bus.opcode, 64'd0);
    step("jal", 1'b1, 32'hFF9FF0EF, 64'h101C);
    step("srai", 1'b1, 32'h43F0D093, 64'h1020);
    step("sraiw", 1'b1, 32'h41F0D09B, 64'h1024);
    step("sd", 1'b1, 32'hFE113C23, 64'h1028);
    step("remuw", 1'b1, 32'h0220F0BB, 64'h102C);
    step("ecall", 1'b1, 32'h00000073, 64'h1030);
    step("fence", 1'b1, 32'h0FF0000F, 64'h1034);
    step("low_bits", 1'b1, 32'h00500090, 64'h1038);

    step("b2b0", 1'b1, 32'h00A00113, 64'h2000);
    step("b2b1", 1'b1, 32'h40208233, 64'h2004);
    step("b2b2", 1'b1, 32'h0000A303, 64'h2008);
    step("b2b_idle", 1'b0, 32'h12345678, 64'hDEAD);
    chk("b2b_idle.spec_npc", bus.IDEX_npc, 64'h2008);
    step("b2b_idle2", 1'b0, 32'h0, 64'h0);

    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        step("rand_raw", ($urandom_range(0, 4) != 0), r, {$urandom, $urandom});
      end else begin
        k = $urandom_range(0, pat_mask.size() - 1);
        step("rand_pat", ($urandom_range(0, 4) != 0), (r & ~pat_mask[k]) | pat_match[k],
             {$urandom, $urandom});
      end
    end

    // Asynchronous reset between edges, then release with no new instruction.
    step("pre_rst", 1'b1, 32'h00500093, 64'h3000);
    #2;
    reset = 1'b0;
    #1;
    clear_exp();
    check_all("async_rst");
    @(negedge clk);
    bus.IFID_ready = 1'b1;
    bus.instr_reg  = 32'h002081B3;
    @(posedge clk);
    #1;
    check_all("rst_held");
    @(negedge clk);
    bus.IFID_ready = 1'b0;
    reset = 1'b1;
    step("post_rst0", 1'b0, 32'h002081B3, 64'h0);
    step("post_rst1", 1'b0, 32'h002081B3, 64'h0);
    step("post_rst_go", 1'b1, 32'h123452B7, 64'h4000);
    step("post_rst_end", 1'b0, 32'h0, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/decode_mod.md
DECODE_MOD -- requirements
Module: decode_mod

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 instr_reg  input  32  RV64IM instruction word from fetch.
REQ-005 IFID_npc  input  64  next-PC of the fetched instruction.
REQ-006 IFID_ready  input  1  instr_reg/IFID_npc valid this cycle.
REQ-007 IDEX_ready  output  1  decoded bundle valid (one-cycle pulse per accepted instruction).
REQ-008 IDEX_npc  output  64  registered copy of IFID_npc.
REQ-009 opcode  output  64  operation code per REQ-014, zero-extended.
REQ-010 rs1, rs2  output  64 each  source register indices instr[19:15] and instr[24:20], zero-extended.
REQ-011 rd  output  6  {1'b0, instr[11:7]}.
REQ-012 immediate  output  20  decoded immediate per REQ-016.

Function
REQ-013 Latency one cycle: on a rising clk with IFID_ready=1, the block SHALL register all outputs from instr_reg/IFID_npc and drive IDEX_ready=1 for exactly the following cycle.
REQ-014 Operation codes SHALL be: 0 ILLEGAL; 1 LUI; 2 AUIPC; 3 JAL; 4 JALR; 5-10 BEQ,BNE,BLT,BGE,BLTU,BGEU; 11-17 LB,LH,LW,LD,LBU,LHU,LWU; 18-21 SB,SH,SW,SD; 22-30 ADDI,SLTI,SLTIU,XORI,ORI,ANDI,SLLI,SRLI,SRAI; 31-40 ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND; 41-44 ADDIW,SLLIW,SRLIW,SRAIW; 45-49 ADDW,SUBW,SLLW,SRLW,SRAW; 50-57 MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU; 58-62 MULW,DIVW,DIVUW,REMW,REMUW; 63 ECALL; 64 FENCE.
REQ-015 Decoding SHALL use opcode[6:0], funct3, and funct7 (funct6 for 64-bit shift immediates); any unlisted encoding, including instr[1:0]!=2'b11, SHALL yield opcode 0, with IDEX_ready still pulsed.
REQ-016 Immediate format:
- I-type: instr[31:20] sign-extended to 20 bits.
- S-type: {instr[31:25],instr[11:7]} sign-extended.
- B-type: {instr[31],instr[7],instr[30:25],instr[11:8],1'b0} sign-extended.
- U-type: instr[31:12].
- J-type: {instr[31],instr[19:12],instr[20],instr[30:21]} (offset>>1).
- SLLI/SRLI/SRAI: instr[25:20] zero-extended.
- *IW shifts: instr[24:20] zero-extended.
- R-type, ECALL, FENCE, ILLEGAL: 0.
REQ-017 rs1/rs2/rd fields SHALL be emitted raw regardless of format (no masking for unused fields).
REQ-018 When IFID_ready=0 at a clock edge, IDEX_ready SHALL be 0 next cycle and all other outputs SHALL hold their previous values.
REQ-019 Back-to-back IFID_ready=1 SHALL yield back-to-back IDEX_ready=1 with no bubbles; no backpressure input exists.
REQ-020 Output logic SHALL be purely registered (no combinational path from inputs to outputs).

Reset
REQ-021 While reset=0, all outputs SHALL be 0 immediately (asynchronously), regardless of clk.
REQ-022 Reset asserted mid-operation SHALL discard the in-flight instruction; the first IDEX_ready after deassertion SHALL follow the first IFID_ready=1 sampled after release.

Verification
REQ-023 0x00500093 (ADDI x1,x0,5), IFID_npc=0x1004, IFID_ready pulse -> next cycle IDEX_ready=1, opcode=22, rd=1, rs1=0, immediate=0x00005, IDEX_npc=0x1004.
REQ-024 0x002081B3 (ADD x3,x1,x2) -> opcode=31, rd=3, rs1=1, rs2=2, immediate=0.
REQ-025 0xFFF00093 -> immediate=0xFFFFF; 0xFE000EE3 (BEQ x0,x0,-4) -> opcode=5, immediate=0xFFFFC.
REQ-026 0x123452B7 (LUI x5,0x12345) -> opcode=1, rd=5, immediate=0x12345; 0xFFFFFFFF -> opcode=0, IDEX_ready=1.
REQ-027 Three consecutive IFID_ready=1 cycles, then IFID_ready=0 -> three consecutive IDEX_ready pulses, then 0 with outputs held at the third instruction.
REQ-028 reset=0 asserted between clock edges after a decode -> all outputs 0 before the next edge; after release with IFID_ready=0 -> IDEX_ready stays 0.
